// File: rtl/bus_mailbox.sv
// bus_mailbox: bus-mapped TX/RX word FIFOs with status, sticky errors and clear; BUS_MAILBOX_IRQ_EN adds CTRL and irq
module bus_mailbox #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        start,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  be,
    input  logic [3:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef BUS_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    logic [31:0] tx_mem [DEPTH];
    logic [31:0] rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_count, rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_ovf, rx_unf, be_err;
    logic [1:0] ctrl;
    logic [1:0] off;
    logic acc, bus_wr, bus_rd, data_wr, data_rd;
    logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop, flush;
    logic [31:0] status, rd_word;
    logic unused_bits;

    assign unused_bits = &{1'b0, address[1:0]};
    assign off = address[3:2];
    // A transaction is taken only on its start cycle, so held strobes never repeat it
    assign acc = chipselect & start & (read ^ write);
    assign bus_wr = acc & write;
    assign bus_rd = acc & read;
    assign data_wr = bus_wr & (off == 2'd0);
    assign data_rd = bus_rd & (off == 2'd0);
    assign flush = bus_wr & (off == 2'd3) & writedata[8];

    assign tx_full = tx_count[DEPTH_LOG2];
    assign tx_empty = tx_count == '0;
    assign rx_full = rx_count[DEPTH_LOG2];
    assign rx_empty = rx_count == '0;

    assign tx_valid = !tx_empty;
    assign tx_data = tx_mem[tx_rd];
    assign rx_ready = !rx_full;

    assign tx_pop = tx_valid & tx_ready;
    assign tx_push_req = data_wr & (be == 4'hF);
    // A full TX still takes the word when the consumer frees a slot in the same cycle
    assign tx_push = tx_push_req & (!tx_full | tx_pop);
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop = data_rd & !rx_empty;

    assign status = {16'd0, 4'(rx_count), 4'(tx_count), 1'b0, be_err, rx_unf, tx_ovf,
                     rx_empty, rx_full, tx_empty, tx_full};

    // Read mux; an empty RX returns zero rather than bypassing a same-cycle push
    always_comb begin
        rd_word = (off == 2'd0) ? (rx_empty ? 32'd0 : rx_mem[rx_rd]) :
                  (off == 2'd1) ? status :
                  (off == 2'd2) ? {30'd0, ctrl} : 32'd0;
    end

    // FIFO storage, written only where the pointer logic accepts a push
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr] <= writedata;
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    // TX pointers and occupancy; flush wins over any concurrent traffic
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr <= '0;
            tx_rd <= '0;
            tx_count <= '0;
        end else if (flush) begin
            tx_wr <= '0;
            tx_rd <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop) tx_rd <= tx_rd + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // RX pointers and occupancy; flush wins over any concurrent traffic
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr <= '0;
            rx_rd <= '0;
            rx_count <= '0;
        end else if (flush) begin
            rx_wr <= '0;
            rx_rd <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop) rx_rd <= rx_rd + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // Sticky error flags: set by the failing access, cleared by CLEAR bits 4..6
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
            be_err <= 1'b0;
        end else begin
            if (tx_push_req && !tx_push) tx_ovf <= 1'b1;
            else if (bus_wr && off == 2'd3 && writedata[4]) tx_ovf <= 1'b0;
            if (data_rd && rx_empty) rx_unf <= 1'b1;
            else if (bus_wr && off == 2'd3 && writedata[5]) rx_unf <= 1'b0;
            if (data_wr && be != 4'hF) be_err <= 1'b1;
            else if (bus_wr && off == 2'd3 && writedata[6]) be_err <= 1'b0;
        end
    end

    // Registered read result, held until the next accepted read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else if (bus_rd) readdata <= rd_word;
    end

`ifdef BUS_MAILBOX_IRQ_EN
    // CTRL register (byte 0 only) and the registered interrupt level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= '0;
            irq <= 1'b0;
        end else begin
            if (bus_wr && off == 2'd2 && be[0]) ctrl <= writedata[1:0];
            irq <= (ctrl[0] & !rx_empty) | (ctrl[1] & tx_empty);
        end
    end
`else
    assign ctrl = '0;
`endif
endmodule
